// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the register file and its scoreboard.
// Holds the default width/depth and the hard-wired zero register address.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned ZERO_ADDR    = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits for in-flight writes.
// Ports: clk, rst (sync, active-high), set_en/set_addr mark a register busy,
// clr_en/clr_addr clear it on writeback, busy_vec holds the registered bits.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_nxt;

    // Clear is applied before set so a same-cycle set on the same register
    // wins: the new producer is still outstanding after the old writeback.
    always_comb begin
        busy_nxt = busy_vec;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_en && clr_addr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (set_en && set_addr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_nxt[ZERO_ADDR] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 2-read/1-write register file with busy scoreboard.
// Ports: addr_a/addr_b -> a/b and busy_a/busy_b (combinational reads),
// addr_d/data/write (write port, also clears busy), busy_set/busy_addr
// (mark in-flight), busy_vec (registered busy bits), clk, rst (sync high).
module reg_file_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [ADDR_W-1:0]   addr_b,
    output logic [DATA_W-1:0]   a,
    output logic [DATA_W-1:0]   b,
    input  logic [ADDR_W-1:0]   addr_d,
    input  logic [DATA_W-1:0]   data,
    input  logic                write,
    input  logic                busy_set,
    input  logic [ADDR_W-1:0]   busy_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic zero_a;
    logic zero_b;
    logic zero_d;
    logic wr_ok;
    logic fwd_a;
    logic fwd_b;

    assign zero_a = ZERO_REG && (addr_a == ZA);
    assign zero_b = ZERO_REG && (addr_b == ZA);
    assign zero_d = ZERO_REG && (addr_d == ZA);
    assign wr_ok  = write && !zero_d;
    assign fwd_a  = BYPASS && wr_ok && (addr_d == addr_a);
    assign fwd_b  = BYPASS && wr_ok && (addr_d == addr_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[addr_d] <= data;
        end
    end

    always_comb begin
        a = regs[addr_a];
        if (fwd_a) begin
            a = data;
        end
        if (zero_a) begin
            a = '0;
        end
    end

    always_comb begin
        b = regs[addr_b];
        if (fwd_b) begin
            b = data;
        end
        if (zero_b) begin
            b = '0;
        end
    end

    // A writeback landing this cycle resolves the hazard early.
    assign busy_a = busy_vec[addr_a] && !fwd_a && !zero_a;
    assign busy_b = busy_vec[addr_b] && !fwd_b && !zero_b;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (busy_set),
        .set_addr (busy_addr),
        .clr_en   (write),
        .clr_addr (addr_d),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed bench for reg_file_scoreboard.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr_d;
    logic [31:0] data;
    logic        write;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic        busy_a;
    logic        busy_b;
    logic [31:0] busy_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .a         (a),
        .b         (b),
        .addr_d    (addr_d),
        .data      (data),
        .write     (write),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_vec  (busy_vec)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        addr_a    = '0;
        addr_b    = '0;
        addr_d    = '0;
        data      = '0;
        write     = 1'b0;
        busy_set  = 1'b0;
        busy_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state across every address.
        for (int i = 0; i < 32; i++) begin
            addr_a = 5'(i);
            addr_b = 5'(31 - i);
            #1;
            chk($sformatf("rst_a[%0d]", i), a, 32'h0);
            chk($sformatf("rst_b[%0d]", i), b, 32'h0);
        end
        chk("rst_busy_vec", busy_vec, 32'h0);
        tick();

        // Same-cycle bypass then stored value.
        write  = 1'b1;
        addr_d = 5'd5;
        data   = 32'hDEADBEEF;
        addr_a = 5'd5;
        addr_b = 5'd4;
        #1;
        chk("byp_a", a, 32'hDEADBEEF);
        chk("byp_b_other", b, 32'h0);
        tick();
        write  = 1'b0;
        addr_b = 5'd5;
        #1;
        chk("stored_a", a, 32'hDEADBEEF);
        chk("stored_b", b, 32'hDEADBEEF);

        // Register 0 ignores writes and bypass.
        write  = 1'b1;
        addr_d = 5'd0;
        data   = 32'h12345678;
        addr_a = 5'd0;
        #1;
        chk("zero_byp", a, 32'h0);
        tick();
        write = 1'b0;
        #1;
        chk("zero_rd", a, 32'h0);
        chk("zero_busy_a", 32'(busy_a), 32'h0);

        // Busy set, then clear via write with same-cycle bypass.
        busy_set  = 1'b1;
        busy_addr = 5'd7;
        tick();
        busy_set = 1'b0;
        addr_a   = 5'd7;
        addr_b   = 5'd7;
        #1;
        chk("busy7_vec", busy_vec, 32'h0000_0080);
        chk("busy7_a", 32'(busy_a), 32'h1);
        chk("busy7_b", 32'(busy_b), 32'h1);
        write  = 1'b1;
        addr_d = 5'd7;
        data   = 32'h0000_0077;
        #1;
        chk("clr7_busy_a", 32'(busy_a), 32'h0);
        chk("clr7_busy_b", 32'(busy_b), 32'h0);
        chk("clr7_vec_hold", busy_vec, 32'h0000_0080);
        tick();
        write = 1'b0;
        #1;
        chk("clr7_vec", busy_vec, 32'h0);
        chk("clr7_data", a, 32'h0000_0077);

        // Write to a different register leaves busy_a untouched.
        busy_set  = 1'b1;
        busy_addr = 5'd8;
        tick();
        busy_set = 1'b0;
        write    = 1'b1;
        addr_d   = 5'd9;
        data     = 32'h1111_1111;
        addr_a   = 5'd8;
        #1;
        chk("busy8_other_wr", 32'(busy_a), 32'h1);
        tick();
        write = 1'b0;

        // Set wins over clear on the same register; data still lands.
        busy_set  = 1'b1;
        busy_addr = 5'd9;
        write     = 1'b1;
        addr_d    = 5'd9;
        data      = 32'hCAFEF00D;
        tick();
        busy_set = 1'b0;
        write    = 1'b0;
        addr_a   = 5'd9;
        #1;
        chk("set_win_vec", busy_vec, 32'h0000_0300);
        chk("set_win_data", a, 32'hCAFEF00D);
        chk("set_win_busy_a", 32'(busy_a), 32'h1);

        // Busy set on register 0 is ignored.
        busy_set  = 1'b1;
        busy_addr = 5'd0;
        tick();
        busy_set = 1'b0;
        addr_a   = 5'd0;
        #1;
        chk("zero_busy_vec", busy_vec, 32'h0000_0300);
        chk("zero_busy_a2", 32'(busy_a), 32'h0);

        // Reset overrides write and busy_set; bypass still live.
        write  = 1'b1;
        addr_d = 5'd3;
        data   = 32'hA5A5A5A5;
        tick();
        write  = 1'b0;
        addr_a = 5'd3;
        #1;
        chk("pre_rst_r3", a, 32'hA5A5A5A5);
        rst       = 1'b1;
        write     = 1'b1;
        addr_d    = 5'd3;
        data      = 32'h0000_0011;
        busy_set  = 1'b1;
        busy_addr = 5'd4;
        #1;
        chk("rst_cycle_byp", a, 32'h0000_0011);
        tick();
        rst      = 1'b0;
        write    = 1'b0;
        busy_set = 1'b0;
        addr_b   = 5'd9;
        #1;
        chk("post_rst_r3", a, 32'h0);
        chk("post_rst_r9", b, 32'h0);
        chk("post_rst_vec", busy_vec, 32'h0);
        addr_a = 5'd5;
        #1;
        chk("post_rst_r5", a, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning number of architectural registers (power of two, >= 2).
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_REGS), meaning register address width.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 reads 0 and ignores writes and busy-set when 1.
REQ-005 SHALL have parameter BYPASS, default 1, meaning a same-cycle write is forwarded to the read ports when 1.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports addr_a, addr_b  input  ADDR_W  read addresses.
REQ-009 SHALL have ports a, b  output  DATA_W  read data.
REQ-010 SHALL have port addr_d  input  ADDR_W  write address.
REQ-011 SHALL have port data  input  DATA_W  write data.
REQ-012 SHALL have port write  input  1  write enable; also clears the busy bit of addr_d.
REQ-013 SHALL have port busy_set  input  1  marks register busy_addr as having a write in flight.
REQ-014 SHALL have port busy_addr  input  ADDR_W  register to mark busy.
REQ-015 SHALL have ports busy_a, busy_b  output  1  busy status of addr_a / addr_b after write-clear bypass.
REQ-016 SHALL have port busy_vec  output  NUM_REGS  current registered busy bits.

Function
REQ-017 Reads SHALL be combinational (zero latency) from addr_a/addr_b.
REQ-018 Write SHALL update regs[addr_d] at the rising clk edge when write=1 and rst=0.
REQ-019 With ZERO_REG=1, reads of register 0 SHALL return 0, busy_a/busy_b SHALL be 0 for address 0, and writes/busy_set to 0 SHALL be ignored.
REQ-020 With BYPASS=1 and write=1, addr_d==addr_a (and not the ignored zero register), a SHALL equal data in the same cycle; likewise for b.
REQ-021 With BYPASS=0, a/b SHALL return the stored value; new data is visible from the cycle after the write.
REQ-022 busy bit of busy_addr SHALL be set at the clk edge when busy_set=1.
REQ-023 busy bit of addr_d SHALL be cleared at the clk edge when write=1.
REQ-024 busy_set and write to the same register in the same cycle: set SHALL win (bit ends 1; data still written).
REQ-025 busy_a SHALL be busy_vec[addr_a] AND NOT (write AND addr_d==addr_a) when BYPASS=1; plain busy_vec[addr_a] when BYPASS=0; same rule for busy_b.
REQ-026 Both read ports SHALL operate independently, including addr_a==addr_b.

Reset
REQ-027 rst=1 at a clk edge SHALL clear all registers to 0 and all busy bits to 0.
REQ-028 write and busy_set in a reset cycle SHALL be ignored; outputs after that edge: a=b=0, busy_a=busy_b=0, busy_vec=0.
REQ-029 Outputs SHALL remain combinational during rst (bypass still active in the reset cycle).

Structure
REQ-030 Default DATA_W/NUM_REGS and a ZERO_ADDR constant SHALL live in shared package regfile_pkg.
REQ-031 Busy-bit logic SHALL be sub-module reg_scoreboard (inputs set/clear addresses and enables, output busy_vec).
REQ-032 Storage SHALL be a flop array inferred in reg_file_scoreboard; no latches.

Verification
REQ-033 Reset then read all addresses -> a=b=0 and busy_vec=0 for every register.
REQ-034 write=1, addr_d=5, data=32'hDEADBEEF, addr_a=5 same cycle -> a=32'hDEADBEEF immediately (BYPASS=1); next cycle still 32'hDEADBEEF.
REQ-035 write=1, addr_d=0, data=32'h12345678; then read addr_a=0 -> a=0 (ZERO_REG=1).
REQ-036 busy_set, busy_addr=7; next cycle busy_vec[7]=1, busy_a=1 for addr_a=7; write addr_d=7 that cycle -> busy_a=0 same cycle, busy_vec[7]=0 next cycle.
REQ-037 busy_set and write both to register 9 same cycle -> busy_vec[9]=1 next cycle, regs[9] holds the written data.
REQ-038 Write 32'hA5A5A5A5 to reg 3, assert rst with write=1 addr_d=3 -> next cycle reg 3 reads 0, busy_vec=0.
